// File: rtl/div_iter.sv
// Multi-cycle restoring divider for MIPS div/divu: one quotient bit per cycle,
// result held until EX drops the request, cancellable by annul_i.
module div_iter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  // Two's complement negation, wrapping modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] neg_val(input logic [DATA_W-1:0] x);
    return (~x) + DATA_W'(1'b1);
  endfunction

  // Magnitude of a signed operand; the most negative value stays as the unsigned 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x, input logic sgn);
    return (sgn && x[DATA_W-1]) ? neg_val(x) : x;
  endfunction

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [DATA_W-1:0]     dvd_r, dvd_s;   // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]     dsr_r, dsr_s;
  logic [DATA_W-1:0]     rem_r, rem_s;
  logic                  neg_q_r, neg_q_s;
  logic                  neg_r_r, neg_r_s;
  logic [2*DATA_W-1:0]   result_r, result_s;
  logic                  ready_r, ready_s;

  logic [DATA_W:0]       shifted_s;
  logic                  ge_s;
  logic [DATA_W-1:0]     diff_s;

  assign shifted_s = {rem_r, dvd_r[DATA_W-1]};
  assign ge_s      = (shifted_s >= {1'b0, dsr_r});
  // Partial remainder stays below the divisor, so the kept difference fits DATA_W bits.
  assign diff_s    = shifted_s[DATA_W-1:0] - dsr_r;

  assign result_o = result_r;
  assign ready_o  = ready_r;

  // Next-state and datapath update for the divide sequencer.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    dvd_s    = dvd_r;
    dsr_s    = dsr_r;
    rem_s    = rem_r;
    neg_q_s  = neg_q_r;
    neg_r_s  = neg_r_r;
    result_s = result_r;
    ready_s  = ready_r;
    case (state_r)
      FREE: begin
        ready_s  = 1'b0;
        result_s = {(2*DATA_W){1'b0}};
        if (start_i && !annul_i) begin
          dvd_s   = abs_val(opdata1_i, signed_div_i);
          dsr_s   = abs_val(opdata2_i, signed_div_i);
          rem_s   = {DATA_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          neg_q_s = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_r_s = signed_div_i & opdata1_i[DATA_W-1];
          if (opdata2_i == {DATA_W{1'b0}}) begin
            state_s = BYZERO;
          end else begin
            state_s = ON;
          end
        end else begin
          state_s = FREE;
        end
      end
      BYZERO: begin
        result_s = {(2*DATA_W){1'b0}};
        if (annul_i) begin
          state_s = FREE;
          ready_s = 1'b0;
        end else begin
          state_s = END;
          ready_s = 1'b1;
        end
      end
      ON: begin
        if (annul_i) begin
          state_s  = FREE;
          cnt_s    = {CNT_W{1'b0}};
          ready_s  = 1'b0;
          result_s = {(2*DATA_W){1'b0}};
        end else if (cnt_r < CNT_W'(DATA_W)) begin
          rem_s = ge_s ? diff_s : shifted_s[DATA_W-1:0];
          dvd_s = {dvd_r[DATA_W-2:0], ge_s};
          cnt_s = cnt_r + CNT_W'(1'b1);
        end else begin
          result_s = {(neg_r_r ? neg_val(rem_r) : rem_r),
                      (neg_q_r ? neg_val(dvd_r) : dvd_r)};
          ready_s  = 1'b1;
          state_s  = END;
        end
      end
      END: begin
        if (!start_i || annul_i) begin
          state_s  = FREE;
          ready_s  = 1'b0;
          result_s = {(2*DATA_W){1'b0}};
        end else begin
          state_s = END;
        end
      end
      default: begin
        state_s  = FREE;
        cnt_s    = {CNT_W{1'b0}};
        ready_s  = 1'b0;
        result_s = {(2*DATA_W){1'b0}};
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= FREE;
      cnt_r    <= {CNT_W{1'b0}};
      dvd_r    <= {DATA_W{1'b0}};
      dsr_r    <= {DATA_W{1'b0}};
      rem_r    <= {DATA_W{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      result_r <= {(2*DATA_W){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      dvd_r    <= dvd_s;
      dsr_r    <= dsr_s;
      rem_r    <= rem_s;
      neg_q_r  <= neg_q_s;
      neg_r_r  <= neg_r_s;
      result_r <= result_s;
      ready_r  <= ready_s;
    end
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle iterative divider. It is the responder to the EX stage's divide request: it accepts `div_start_o`, `div_op1_o`, `div_op2_o` and `div_signed_o` from EX, and returns `div_result_i` and `div_ready_i` to EX.
- It performs a restoring shift-subtract division, one quotient bit per cycle, for MIPS div/divu.
- It holds the result until EX releases the request. It also supports cancellation when the pipeline is flushed.

Parameters:
- DATA_W, 32, operand width. Quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- signed_div_i  input  1  1 = signed (div), 0 = unsigned (divu).
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- start_i  input  1  request; EX holds it high until it sees ready_o.
- annul_i  input  1  cancel the in-flight division (flush/exception).
- result_o  output  2*DATA_W  {remainder, quotient}. Upper half goes to Hi, lower half goes to Lo.
- ready_o  output  1  result valid.

Behaviour:
- Reset (rst low, async): state=FREE, counter=0, internal registers=0, result_o=0, ready_o=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States are FREE, BYZERO, ON, END.
- FREE:
  - On start_i=1 and annul_i=0, capture the operands and signed_div_i.
  - If opdata2_i==0, go to BYZERO.
  - Otherwise go to ON with counter=0.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- Operand capture:
  - When signed, divide the absolute values, computed by two's complement.
  - abs(-2^(DATA_W-1)) is kept as the unsigned 2^(DATA_W-1).
  - Input changes after capture are ignored.
- BYZERO: next edge goes to END with result_o=0 and ready_o=1.
- ON:
  - Each edge with counter<DATA_W:
    - Shift the partial remainder left 1 bit, bringing in the next dividend bit (MSB first).
    - Trial-subtract the divisor.
    - If the difference is non-negative, keep it and shift in quotient bit 1; else keep the remainder and shift in 0.
    - counter++.
  - Edge with counter==DATA_W:
    - Apply sign correction.
    - Register the result, set ready_o=1, go to END.
  - If annul_i=1 on any ON edge, go to FREE with counter=0, ready_o=0, result_o=0. annul_i takes precedence over iteration.
- Sign correction (signed only):
  - quotient negated if sign(op1) XOR sign(op2).
  - remainder negated if sign(op1) is 1.
  - Results wrap modulo 2^DATA_W: -2^31 / -1 gives quotient 0x80000000, remainder 0.
- END:
  - result_o and ready_o hold while start_i=1.
  - On start_i=0 or annul_i=1: next edge goes to FREE with ready_o=0 and result_o=0.
  - A new request is accepted only from FREE. Back-to-back divides therefore need at least one cycle with start_i low.
- Latency:
  - Nonzero divisor: ready_o is high after the (DATA_W+2)th rising edge, counting the FREE edge that samples start_i as the 1st. This is 34 edges for DATA_W=32.
  - Zero divisor: ready_o is high after the 2nd edge.
- ready_o is a single level. It is never high outside END.
- Reset mid-operation aborts immediately with no residual state.

Test Plan:
- Unsigned 100 / 7 (start held high): ready_o rises after edge 34 → result_o = 0x00000002_0000000E. Drop start_i → next edge ready_o=0, result_o=0.
- Signed -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001. Unsigned 0xFFFFFFF9 / 2 → quotient 0x7FFFFFFC, remainder 1.
- Divide by zero: opdata2_i=0, both signed and unsigned → ready_o after edge 2, result_o=0. Also change opdata1_i/opdata2_i in the cycle after start is accepted → result unaffected.
- Boundary:
  - Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
  - Unsigned same operands → quotient 0, remainder 0x80000000.
  - 0 / 5 → 0.
  - 0xFFFFFFFF / 1 unsigned → quotient 0xFFFFFFFF.
- Cancel: annul_i pulsed on edge 10 of ON → state FREE, ready_o never asserts. Next request 50 / 5 completes in 34 edges with quotient 10, remainder 0.
- Hold and reset:
  - Hold start_i high 5 cycles in END → ready_o and result_o stable.
  - Assert rst low asynchronously mid-ON (between edges) → ready_o=0 and result_o=0 immediately. After release, a new divide completes correctly.
